ins_fetch: RTL and testbench
============================

// Module: ins_fetch
// PURPOSE
//  Instruction fetch/sequencing stage directly upstream of the 4-bit opcode decoder.
//  Owns the PC and reads instruction bytes from program memory over a req/ack handshake.
//  Latches opcode/operand plus an optional immediate byte, and pulses decoder enable for one cycle.
//  Waits for the execute stage, then applies jump/halt and fetches the next instruction.
// PARAMETERS
//  PC_W    8   PC / memory address width; PC wraps modulo 2**PC_W
//  RST_PC  0   PC value loaded on reset
// PORTS
//  clk        in   1     system clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  mem_addr   out  PC_W  program memory byte address (= pc while mem_req=1)
//  mem_req    out  1     read request; held until mem_ack
//  mem_ack    in   1     read data valid this cycle; ignored when mem_req=0
//  mem_rdata  in   8     instruction byte {opcode[7:4], operand[3:0]}
//  ir         out  4     latched opcode, feeds decoder ir
//  operand    out  4     latched low nibble
//  imm        out  8     second byte for jmp(1010), jg(1011), movi(1110); else unchanged
//  en         out  1     decoder enable, one-cycle pulse per legal instruction
//  exec_done  in   1     execute stage finished current instruction
//  jump_take  in   1     valid with exec_done: load pc <= imm[PC_W-1:0]
//  halt_i     in   1     decoded halt, valid with exec_done
//  pc         out  PC_W  address of next byte to fetch
//  halted     out  1     high in S_HALT
//  illegal    out  1     one-cycle pulse on opcode 0000..0011
// BEHAVIOUR
//  Reset (async, any state, including mid-handshake):
//   - state=S_IDLE, pc=RST_PC, ir=0, operand=0, imm=0
//   - en=0, mem_req=0, halted=0, illegal=0
//  mem_req = (state==S_FETCH || state==S_FETCH2); mem_addr = pc; both combinational from registered state.
//  States:
//   S_IDLE   -> S_FETCH next cycle (first request one cycle after rst release).
//   S_FETCH  on mem_ack: ir<=rdata[7:4], operand<=rdata[3:0], pc<=pc+1.
//            opcode in {1010,1011,1110} -> S_FETCH2.
//            opcode 0100..1111 otherwise -> S_DECODE.
//            opcode 0000..0011 -> illegal=1 for one cycle, stay S_FETCH (skipped, no en).
//   S_FETCH2 on mem_ack: imm<=rdata, pc<=pc+1 -> S_DECODE.
//   S_DECODE en=1 for exactly this cycle -> S_EXEC.
//   S_EXEC   wait exec_done. On exec_done, priority halt_i > jump_take > sequential:
//            halt_i -> S_HALT; jump_take -> pc<=imm, S_FETCH; else S_FETCH.
//            jump_take/halt_i ignored without exec_done.
//   S_HALT   halted=1, no requests; exit only via rst.
//  Latency: 1-byte instr, ack in request cycle -> en 1 cycle after ack edge (fetch 1 + decode 1).
//   2-byte: +1 cycle per extra byte plus memory wait cycles.
//  Handshake: mem_addr stable while mem_req=1 and no ack. Back-to-back: next request starts
//   the cycle after exec_done.
//  PC arithmetic: unsigned PC_W bits; pc=2**PC_W-1 increments to 0 (second byte may wrap).
//  ir/operand/imm hold value from latch until next latch; the decoder sees stable ir while en=1.
// CONFIGURATION
//  INS_FETCH_STEP_EN defined:
//   - adds input port step (1 bit) and state S_WAIT.
//   - S_EXEC non-halt exit goes to S_WAIT (pc update applied on exit from S_EXEC).
//   - S_WAIT -> S_FETCH on step=1; step high holds one instruction per pulse-cycle seen.
//   - step ignored in all other states.
//  INS_FETCH_STEP_EN undefined: no step port, no S_WAIT; free-running as above.
// TESTING
//  1 rst 3 cycles, mem @0=0x45, ack same cycle -> mem_req rises 1 cycle after rst low;
//    ir=4 (movb), operand=5, en pulses 1 cycle, pc=1.
//  2 @0=0xE0,@1=0x7F (movi), ack delayed 2 cycles each -> mem_addr 0 then 1 held stable;
//    imm=0x7F, en once, pc=2.
//  3 @5=0xA0,@6=0x20 (jmp), exec_done+jump_take -> pc=0x20, next mem_addr=0x20.
//  4 @0=0x10, @1=0xF0 -> illegal pulse at addr 0, no en; halt fetched, exec_done+halt_i+jump_take
//    -> halted=1, pc unchanged, mem_req stays 0.
//  5 PC_W=4, pc=15, fetch 0xB3 then 0x02 -> second byte read from addr 0, pc=1.
//  6 rst asserted while mem_req=1 and no ack -> mem_req=0 and pc=RST_PC immediately (before edge).
//    With INS_FETCH_STEP_EN: no fetch after exec_done until step=1.

Source files
------------

// File: rtl/ins_fetch.sv
// ins_fetch: owns the PC and fetches 1/2-byte instructions from memory.
// Optional single-step gating: define INS_FETCH_STEP_EN.
module ins_fetch #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_req,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    output logic [3:0]      ir,
    output logic [3:0]      operand,
    output logic [7:0]      imm,
    output logic            en,
    input  logic            exec_done,
    input  logic            jump_take,
    input  logic            halt_i,
`ifdef INS_FETCH_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH2,
        S_DECODE,
        S_EXEC,
`ifdef INS_FETCH_STEP_EN
        S_WAIT,
`endif
        S_HALT
    } state_t;

    state_t state;
    state_t state_n;

    logic ld_op;
    logic ld_imm;
    logic pc_inc;
    logic pc_jmp;
    logic ill_n;
    logic op_two;
    logic op_ill;

    assign op_two = (mem_rdata[7:4] == 4'hA) ||
                    (mem_rdata[7:4] == 4'hB) ||
                    (mem_rdata[7:4] == 4'hE);
    assign op_ill = (mem_rdata[7:6] == 2'b00);

    assign mem_req  = (state == S_FETCH) || (state == S_FETCH2);
    assign mem_addr = pc;
    assign en       = (state == S_DECODE);
    assign halted   = (state == S_HALT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and datapath load strobes
    always_comb begin
        state_n = state;
        ld_op   = 1'b0;
        ld_imm  = 1'b0;
        pc_inc  = 1'b0;
        pc_jmp  = 1'b0;
        ill_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_n = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ld_op  = 1'b1;
                    pc_inc = 1'b1;
                    if (op_ill) begin
                        ill_n = 1'b1;
                    end else if (op_two) begin
                        state_n = S_FETCH2;
                    end else begin
                        state_n = S_DECODE;
                    end
                end
            end
            S_FETCH2: begin
                if (mem_ack) begin
                    ld_imm  = 1'b1;
                    pc_inc  = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                state_n = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (halt_i) begin
                        state_n = S_HALT;
                    end else begin
                        pc_jmp = jump_take;
`ifdef INS_FETCH_STEP_EN
                        state_n = S_WAIT;
`else
                        state_n = S_FETCH;
`endif
                    end
                end
            end
`ifdef INS_FETCH_STEP_EN
            S_WAIT: begin
                if (step) begin
                    state_n = S_FETCH;
                end
            end
`endif
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // PC: jump target has priority over sequential increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RST_PC;
        end else if (pc_jmp) begin
            pc <= PC_W'(imm);
        end else if (pc_inc) begin
            pc <= pc + PC_W'(1);
        end
    end

    // Instruction latches hold until the next fetch overwrites them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir      <= 4'h0;
            operand <= 4'h0;
            imm     <= 8'h00;
        end else begin
            if (ld_op) begin
                ir      <= mem_rdata[7:4];
                operand <= mem_rdata[3:0];
            end
            if (ld_imm) begin
                imm <= mem_rdata;
            end
        end
    end

    // One-cycle pulse for a skipped illegal opcode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
        end else begin
            illegal <= ill_n;
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: scoreboard bench for ins_fetch (8-bit and 4-bit PC).
// Monitors pop expected decode records and fetch addresses.
module tb_ins_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [3:0] ir, operand;
    logic [7:0] imm;
    logic       en;
    logic       exec_done, jump_take, halt_i;
    logic       step;
    logic [7:0] pc;
    logic       halted, illegal;

    logic       rst2;
    logic [3:0] mem_addr2;
    logic       mem_req2, mem_ack2;
    logic [7:0] mem_rdata2;
    logic [3:0] ir2, operand2;
    logic [7:0] imm2;
    logic       en2;
    logic       exec_done2, jump_take2, halt_i2;
    logic       step2;
    logic [3:0] pc2;
    logic       halted2, illegal2;

    always #5 clk = ~clk;

    ins_fetch #(.PC_W(8), .RST_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .operand(operand), .imm(imm), .en(en),
        .exec_done(exec_done), .jump_take(jump_take),
        .halt_i(halt_i),
`ifdef INS_FETCH_STEP_EN
        .step(step),
`endif
        .pc(pc), .halted(halted), .illegal(illegal)
    );

    ins_fetch #(.PC_W(4), .RST_PC(4'hF)) dut2 (
        .clk(clk), .rst(rst2),
        .mem_addr(mem_addr2), .mem_req(mem_req2),
        .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
        .ir(ir2), .operand(operand2), .imm(imm2), .en(en2),
        .exec_done(exec_done2), .jump_take(jump_take2),
        .halt_i(halt_i2),
`ifdef INS_FETCH_STEP_EN
        .step(step2),
`endif
        .pc(pc2), .halted(halted2), .illegal(illegal2)
    );

    logic [7:0]  mem  [256];
    logic [7:0]  mem2 [16];
    int          ack_dly;
    int          n_cmp;
    int          n_bad;
    int          en_cnt;
    int          ill_cnt;
    logic [23:0] q1[$];
    logic [7:0]  aq1[$];
    logic [23:0] q2[$];
    logic [7:0]  aq2[$];

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Memory for dut: ack after ack_dly wait cycles
    initial begin
        int wc;
        wc = 0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req && !rst) begin
                if (wc >= ack_dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Memory for dut2: ack in the request cycle
    initial begin
        mem_ack2 = 1'b0;
        mem_rdata2 = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_ack2 = mem_req2 && !rst2;
            mem_rdata2 = mem2[mem_addr2];
        end
    end

    // Execute stage for dut: one busy cycle with junk
    // jump/halt, then done; F=halt (with jump), A=jmp
    initial begin
        int ec;
        ec = -1;
        exec_done = 1'b0;
        jump_take = 1'b0;
        halt_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            exec_done = 1'b0;
            jump_take = 1'b0;
            halt_i = 1'b0;
            if (rst) begin
                ec = -1;
            end else if (ec == 0) begin
                exec_done = 1'b1;
                halt_i = (ir == 4'hF);
                jump_take = (ir == 4'hF) || (ir == 4'hA);
                ec = -1;
            end else if (ec > 0) begin
                jump_take = 1'b1;
                halt_i = 1'b1;
                ec--;
            end
            if (en) ec = 1;
        end
    end

    // Execute stage for dut2: done next cycle, no jumps
    initial begin
        logic pend;
        pend = 1'b0;
        exec_done2 = 1'b0;
        jump_take2 = 1'b0;
        halt_i2 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            exec_done2 = pend;
            halt_i2 = pend && (ir2 == 4'hF);
            pend = en2;
        end
    end

    // Monitor for dut
    initial begin
        logic       pw;
        logic [7:0] pa;
        logic [23:0] e;
        logic [7:0]  ea;
        pw = 1'b0;
        pa = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pw = 1'b0;
            end else begin
                if (en) begin
                    en_cnt++;
                    if (q1.size() == 0) begin
                        check("en_unexpected", 32'(en), 0);
                    end else begin
                        e = q1.pop_front();
                        check("decode_rec",
                              {8'h0, ir, operand, imm, pc}, {8'h0, e});
                    end
                end
                if (illegal) ill_cnt++;
                if (mem_req && mem_ack) begin
                    if (aq1.size() == 0) begin
                        check("ack_unexpected", {24'h0, mem_addr}, 32'hFFFF);
                    end else begin
                        ea = aq1.pop_front();
                        check("fetch_addr", {24'h0, mem_addr}, {24'h0, ea});
                    end
                end
                if (pw && mem_req)
                    check("addr_hold", {24'h0, mem_addr}, {24'h0, pa});
                pw = mem_req && !mem_ack;
                pa = mem_addr;
            end
        end
    end

    // Monitor for dut2
    initial begin
        logic [23:0] e;
        logic [7:0]  ea;
        forever begin
            @(negedge clk);
            if (!rst2) begin
                if (en2) begin
                    if (q2.size() == 0) begin
                        check("en2_unexpected", 32'(en2), 0);
                    end else begin
                        e = q2.pop_front();
                        check("decode_rec2",
                              {8'h0, ir2, operand2, imm2, 4'h0, pc2},
                              {8'h0, e});
                    end
                end
                if (mem_req2 && mem_ack2) begin
                    if (aq2.size() == 0) begin
                        check("ack2_unexpected", {28'h0, mem_addr2}, 32'hFFFF);
                    end else begin
                        ea = aq2.pop_front();
                        check("fetch_addr2", {28'h0, mem_addr2}, {24'h0, ea});
                    end
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en_cnt = 0;
        ill_cnt = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string nm);
        int n;
        n = 0;
        while (!halted && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(nm, 32'(halted), 1);
    endtask

    task automatic end_test(input string nm);
        check({nm, "_recs_left"}, q1.size(), 0);
        check({nm, "_addrs_left"}, aq1.size(), 0);
        q1.delete();
        aq1.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_cmp = 0;
        n_bad = 0;
        ack_dly = 0;
        step = 1'b1;
        step2 = 1'b1;
        rst = 1'b1;
        rst2 = 1'b1;
        en_cnt = 0;
        ill_cnt = 0;
        for (int i = 0; i < 16; i++) mem2[i] = 8'h00;

        // 1: reset state, first fetch timing, 1-byte op
        clear_mem();
        mem[0] = 8'h45;
        mem[1] = 8'hF0;
        q1.push_back({4'h4, 4'h5, 8'h00, 8'h01});
        q1.push_back({4'hF, 4'h0, 8'h00, 8'h02});
        aq1.push_back(8'h00);
        aq1.push_back(8'h01);
        repeat (3) @(posedge clk);
        #2;
        check("rst_pc", {24'h0, pc}, 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_en", 32'(en), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_ir", {28'h0, ir}, 0);
        check("rst_operand", {28'h0, operand}, 0);
        check("rst_imm", {24'h0, imm}, 0);
        rst = 1'b0;
        #1;
        check("req_after_rel", 32'(mem_req), 0);
        @(posedge clk);
        #2;
        check("req_rise", 32'(mem_req), 1);
        check("first_addr", {24'h0, mem_addr}, 0);
        @(posedge clk);
        #2;
        check("en_latency", 32'(en), 1);
        @(posedge clk);
        #2;
        check("en_pulse_end", 32'(en), 0);
        wait_halt("t1_halt");
        check("t1_pc", {24'h0, pc}, 2);
        check("t1_en_cnt", en_cnt, 2);
        end_test("t1");

        // 2: movi, two-cycle memory wait on each byte
        clear_mem();
        mem[0] = 8'hE0;
        mem[1] = 8'h7F;
        mem[2] = 8'hF0;
        ack_dly = 2;
        q1.push_back({4'hE, 4'h0, 8'h7F, 8'h02});
        q1.push_back({4'hF, 4'h0, 8'h7F, 8'h03});
        aq1.push_back(8'h00);
        aq1.push_back(8'h01);
        aq1.push_back(8'h02);
        do_reset();
        wait_halt("t2_halt");
        check("t2_pc", {24'h0, pc}, 3);
        check("t2_en_cnt", en_cnt, 2);
        end_test("t2");

        // 3: jmp chain 0 -> 5 -> 0x20
        clear_mem();
        mem[0] = 8'hA0;
        mem[1] = 8'h05;
        mem[5] = 8'hA0;
        mem[6] = 8'h20;
        mem[8'h20] = 8'hF0;
        ack_dly = 1;
        q1.push_back({4'hA, 4'h0, 8'h05, 8'h02});
        q1.push_back({4'hA, 4'h0, 8'h20, 8'h07});
        q1.push_back({4'hF, 4'h0, 8'h20, 8'h21});
        aq1.push_back(8'h00);
        aq1.push_back(8'h01);
        aq1.push_back(8'h05);
        aq1.push_back(8'h06);
        aq1.push_back(8'h20);
        do_reset();
        wait_halt("t3_halt");
        check("t3_pc", {24'h0, pc}, 8'h21);
        end_test("t3");

        // 4: illegal skip, then halt beats jump_take
        clear_mem();
        mem[0] = 8'h10;
        mem[1] = 8'hF0;
        ack_dly = 0;
        q1.push_back({4'hF, 4'h0, 8'h00, 8'h02});
        aq1.push_back(8'h00);
        aq1.push_back(8'h01);
        do_reset();
        wait_halt("t4_halt");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("t4_req_idle", 32'(mem_req), 0);
        end
        check("t4_halted", 32'(halted), 1);
        check("t4_pc", {24'h0, pc}, 2);
        check("t4_ill_cnt", ill_cnt, 1);
        check("t4_en_cnt", en_cnt, 1);
        end_test("t4");

        // 6: async reset in the middle of a pending fetch
        clear_mem();
        mem[0] = 8'h45;
        mem[1] = 8'hF0;
        ack_dly = 0;
        q1.push_back({4'h4, 4'h5, 8'h00, 8'h01});
        aq1.push_back(8'h00);
        do_reset();
        n = 0;
        while (!en && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("t6_en_seen", 32'(en), 1);
        ack_dly = 20;
        n = 0;
        while (!(mem_req && pc == 8'h01) && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("t6_pending", 32'(mem_req), 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_req_async", 32'(mem_req), 0);
        check("t6_pc_async", {24'h0, pc}, 0);
        check("t6_ir_async", {28'h0, ir}, 0);
        @(posedge clk);
        #2;
        end_test("t6");

`ifdef INS_FETCH_STEP_EN
        // step gating: no fetch after exec_done until step
        clear_mem();
        mem[0] = 8'h45;
        mem[1] = 8'hF0;
        ack_dly = 0;
        step = 1'b0;
        q1.push_back({4'h4, 4'h5, 8'h00, 8'h01});
        q1.push_back({4'hF, 4'h0, 8'h00, 8'h02});
        aq1.push_back(8'h00);
        aq1.push_back(8'h01);
        do_reset();
        repeat (10) @(posedge clk);
        #2;
        check("step_req_wait", 32'(mem_req), 0);
        check("step_pc_wait", {24'h0, pc}, 1);
        check("step_en_cnt", en_cnt, 1);
        step = 1'b1;
        @(posedge clk);
        #2;
        step = 1'b0;
        check("step_req_go", 32'(mem_req), 1);
        wait_halt("step_halt");
        check("step_pc", {24'h0, pc}, 2);
        step = 1'b1;
        end_test("step");
`endif

        // 5: 4-bit PC wraps 15 -> 0 between bytes
        mem2[15] = 8'hB3;
        mem2[0] = 8'h02;
        mem2[1] = 8'hF0;
        q2.push_back({4'hB, 4'h3, 8'h02, 8'h01});
        q2.push_back({4'hF, 4'h0, 8'h02, 8'h02});
        aq2.push_back(8'h0F);
        aq2.push_back(8'h00);
        aq2.push_back(8'h01);
        check("t5_rst_pc", {28'h0, pc2}, 4'hF);
        @(posedge clk);
        #2;
        rst2 = 1'b0;
        n = 0;
        while (!halted2 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("t5_halt", 32'(halted2), 1);
        check("t5_pc", {28'h0, pc2}, 2);
        check("t5_recs_left", q2.size(), 0);
        check("t5_addrs_left", aq2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
